// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO write-port arbiter
package fifo_arb_pkg;

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_MAX_BURST  = 4;

   function automatic int grant_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: requester handshake plus FIFO write-port signals
interface fifo_write_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   localparam int GW = grant_w(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          full;
   logic                          w_en;
   logic [DATA_WIDTH-1:0]         data_in;
   logic [GW-1:0]                 grant_id;
   logic                          busy;

   modport master (
      output req_valid, req_data, req_last, full,
      input  req_ready, w_en, data_in, grant_id, busy
   );

   modport slave (
      input  req_valid, req_data, req_last, full,
      output req_ready, w_en, data_in, grant_id, busy
   );

endinterface

// File: rtl/fifo_write_arbiter_rr_priority_picker.sv
// rr_priority_picker: round-robin winner search starting just after last_grant
module rr_priority_picker
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int GW      = grant_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GW-1:0]      last_grant,
   output logic [GW-1:0]      winner,
   output logic               any_valid
);

   logic [GW-1:0] idx;

   // scan from farthest to nearest so the nearest requester after last_grant wins
   always_comb begin
      winner = '0;
      idx    = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = GW'((int'(last_grant) + k) % NUM_REQ);
         if (req[idx]) winner = idx;
      end
      any_valid = |req;
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of the FIFO write port with bounded bursts
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MAX_BURST  = DEF_MAX_BURST
) (
   input logic                 clk_master,
   input logic                 reset,
   fifo_write_arbiter_if.slave bus
);

   localparam int GW = grant_w(NUM_REQ);
   localparam int BW = grant_w(MAX_BURST);

   state_t        state, state_n;
   logic [GW-1:0] grant_id, grant_n, last_grant, last_n, winner;
   logic [BW-1:0] beat_cnt, beat_n;
   logic          any_valid, sel_valid, sel_last, xfer;

   rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req        (bus.req_valid),
      .last_grant (last_grant),
      .winner     (winner),
      .any_valid  (any_valid)
   );

   assign sel_valid     = bus.req_valid[grant_id];
   assign sel_last      = bus.req_last[grant_id];
   assign xfer          = (state == GRANT) && sel_valid && !bus.full;
   assign bus.w_en      = xfer;
   assign bus.req_ready = NUM_REQ'(xfer) << grant_id;
   assign bus.data_in   = (state == GRANT) ? bus.req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign bus.grant_id  = grant_id;
   assign bus.busy      = (state == GRANT);

   // state and grant bookkeeping; reset clears everything without waiting for a clock
   always_ff @(posedge clk_master or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         grant_id   <= '0;
         beat_cnt   <= '0;
         last_grant <= GW'(NUM_REQ - 1);
      end else begin
         state      <= state_n;
         grant_id   <= grant_n;
         beat_cnt   <= beat_n;
         last_grant <= last_n;
      end
   end

   // arbitrate in IDLE; in GRANT count beats and release on last, burst limit or dropped valid
   always_comb begin
      state_n = state;
      grant_n = grant_id;
      beat_n  = beat_cnt;
      last_n  = last_grant;
      if (state == IDLE) begin
         if (any_valid) begin
            state_n = GRANT;
            grant_n = winner;
            beat_n  = '0;
         end
      end else if (xfer) begin
         beat_n = beat_cnt + BW'(1);
         if (sel_last || beat_cnt == BW'(MAX_BURST - 1)) begin
            state_n = IDLE;
            last_n  = grant_id;
         end
      end else if (!sel_valid) begin
         state_n = IDLE;
         last_n  = grant_id;
      end
   end

endmodule
